stat_resp_misr: RTL

//  Response compactor directly downstream of the generated 32-in/32-out Stat benchmark netlists.

---
 rtl/stat_harness_pkg.sv | 22 ++
 rtl/stat_misr_core.sv | 40 ++++
 rtl/stat_resp_misr.sv | 122 ++++++++++++
 3 files changed

// File: rtl/stat_harness_pkg.sv
// Shared types, constants and the MISR step function for the Stat benchmark harness.
package stat_harness_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int STAT_IO_W = 32;
    localparam logic [STAT_IO_W-1:0] CRC32_POLY = 32'h04C11DB7;

    // One MISR step: shift left, fold the outgoing MSB back through the taps, xor in the response.
    function automatic logic [STAT_IO_W-1:0] misr_next(
        input logic [STAT_IO_W-1:0] sig,
        input logic [STAT_IO_W-1:0] data,
        input logic [STAT_IO_W-1:0] poly
    );
        return {sig[STAT_IO_W-2:0], 1'b0} ^ (sig[STAT_IO_W-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/stat_misr_core.sv
// Signature register: load reseeds, enable folds one response word into the signature.
module stat_misr_core
    import stat_harness_pkg::*;
#(
    parameter int                 WIDTH = STAT_IO_W,
    parameter logic [WIDTH-1:0]   POLY  = CRC32_POLY,
    parameter logic [WIDTH-1:0]   SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Load outranks enable so a reseed always discards a coincident beat.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = misr_next(sig_q, data, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/stat_resp_misr.sv
// Response compactor: valid/ready beat capture, run FSM and pattern counter around a MISR.
// Optional golden-signature comparator enabled by defining MISR_GOLDEN_CMP_EN.
module stat_resp_misr
    import stat_harness_pkg::*;
#(
    parameter int                 WIDTH        = STAT_IO_W,
    parameter logic [WIDTH-1:0]   POLY         = CRC32_POLY,
    parameter logic [WIDTH-1:0]   SEED         = '0,
    parameter int                 NUM_PATTERNS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic [15:0]      pat_count,
    output logic             sig_valid,
    output logic [WIDTH-1:0] sig_out
`ifdef MISR_GOLDEN_CMP_EN
    ,
    input  logic [WIDTH-1:0] golden_sig,
    output logic             pass
`endif
);

    if ((NUM_PATTERNS < 1) || (NUM_PATTERNS > 65535)) begin : g_bad_num_patterns
        $error("stat_resp_misr: NUM_PATTERNS must be in 1..65535");
    end
    if (WIDTH != STAT_IO_W) begin : g_bad_width
        $error("stat_resp_misr: WIDTH must equal STAT_IO_W");
    end

    localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sig_valid_q, sig_valid_d;
    logic [15:0] cnt_inc;
    logic        accept;
    logic        done_entry;

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign accept     = in_valid && in_ready;
    assign cnt_inc    = cnt_q + 16'd1;
    assign done_entry = !start && accept && (cnt_inc == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_valid_d = sig_valid_q;
        if (start) begin
            state_d     = RUN;
            cnt_d       = '0;
            sig_valid_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d     = DONE;
                            sig_valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    stat_misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .en   (accept),
        .data (in_data),
        .sig  (sig_out)
    );

    assign pat_count = cnt_q;
    assign sig_valid = sig_valid_q;

`ifdef MISR_GOLDEN_CMP_EN
    logic pass_q;

    // Compare the signature being written on the final accept, so pass aligns with sig_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (start) begin
            pass_q <= 1'b0;
        end else if (done_entry) begin
            pass_q <= (misr_next(sig_out, in_data, POLY) == golden_sig);
        end
    end

    assign pass = pass_q;
`else
    logic unused_done_entry;
    assign unused_done_entry = done_entry;
`endif

endmodule
